// File: rtl/ptcalc_mul_pkg.sv
// Shared constants and width helpers for the ptcalc multiplier and scaling stages.
package ptcalc_mul_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int SAT_WRAP      = 0;
  localparam int SAT_CLIP      = 1;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic logic signed [127:0] sat_max(input int w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] sat_min(input int w);
    return -(128'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/ptcalc_mul_round_sat.sv
// Combinational shift / round-half-up / saturate-or-wrap of a signed product down to DOUT_WIDTH.
module ptcalc_mul_round_sat
  import ptcalc_mul_pkg::*;
#(
  parameter int P_WIDTH    = 39,
  parameter int DOUT_WIDTH = 39,
  parameter int SHIFT      = 0,
  parameter int ROUND      = ROUND_HALF_UP,
  parameter int SAT        = SAT_CLIP
) (
  input  logic signed [P_WIDTH-1:0]    p_i,
  output logic signed [DOUT_WIDTH-1:0] dout_o,
  output logic                         sat_o
);

  // One guard bit so the rounding constant can never overflow the sum.
  localparam int RW  = P_WIDTH + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (ROUND == ROUND_HALF_UP && SHIFT > 0) ? (RW'(1) <<< RSH) : '0;

  logic signed [RW-1:0] r;

  assign r = (RW'(p_i) + RND) >>> SHIFT;

  generate
    if (DOUT_WIDTH >= RW) begin : g_ext
      assign dout_o = DOUT_WIDTH'(r);
      assign sat_o  = 1'b0;
    end else begin : g_clip
      localparam logic signed [DOUT_WIDTH-1:0] MAXV = DOUT_WIDTH'(sat_max(DOUT_WIDTH));
      localparam logic signed [DOUT_WIDTH-1:0] MINV = DOUT_WIDTH'(sat_min(DOUT_WIDTH));
      logic [RW-DOUT_WIDTH:0] hi;
      logic                   clip;

      // Result fits when every bit above the output sign bit matches it.
      assign hi   = r[RW-1:DOUT_WIDTH-1];
      assign clip = !((&hi) || !(|hi));

      always_comb begin
        dout_o = r[DOUT_WIDTH-1:0];
        sat_o  = 1'b0;
        if (SAT == SAT_CLIP && clip) begin
          sat_o  = 1'b1;
          dout_o = r[RW-1] ? MINV : MAXV;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ptcalc_mul_pipe.sv
// Pipelined signed multiplier with valid/ready backpressure, scaling and a clip counter.
module ptcalc_mul_pipe
  import ptcalc_mul_pkg::*;
#(
  parameter int A_WIDTH    = 24,
  parameter int B_WIDTH    = 15,
  parameter int DOUT_WIDTH = 39,
  parameter int SHIFT      = 0,
  parameter int ROUND      = ROUND_HALF_UP,
  parameter int SAT        = SAT_CLIP,
  parameter int NUM_STAGE  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [A_WIDTH-1:0]    din0,
  input  logic signed [B_WIDTH-1:0]    din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_sat,
  input  logic                         sat_clr,
  output logic [CNT_WIDTH-1:0]         sat_count
);

  localparam int PW = prod_width(A_WIDTH, B_WIDTH);

  logic                         advance;
  logic [NUM_STAGE:1]           vld_pipe_q;
  logic signed [PW-1:0]         rs_in;
  logic signed [DOUT_WIDTH-1:0] rs_dout;
  logic                         rs_sat;
  logic signed [DOUT_WIDTH-1:0] dout_q;
  logic                         dout_sat_q;
  logic [CNT_WIDTH-1:0]         sat_count_q, sat_count_d;

  // Whole pipe moves in lockstep; bubbles are carried, not squeezed out.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe_q[NUM_STAGE];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)    vld_pipe_q <= '0;
    else if (advance) vld_pipe_q <= (vld_pipe_q << 1) | NUM_STAGE'(in_valid);
  end

  generate
    if (NUM_STAGE == 1) begin : g_ns1
      assign rs_in = PW'(din0) * PW'(din1);
    end else begin : g_nsn
      logic signed [A_WIDTH-1:0] a_q;
      logic signed [B_WIDTH-1:0] b_q;
      logic signed [PW-1:0]      prod;

      always_ff @(posedge ap_clk) begin
        if (advance) begin
          a_q <= din0;
          b_q <= din1;
        end
      end

      assign prod = PW'(a_q) * PW'(b_q);

      if (NUM_STAGE == 2) begin : g_ns2
        assign rs_in = prod;
      end else begin : g_ns3
        // Post-multiply register chain; retimes into DSP M/P registers.
        logic signed [PW-1:0] p_q [2:NUM_STAGE-1];

        always_ff @(posedge ap_clk) begin
          if (advance) begin
            p_q[2] <= prod;
            for (int s = 3; s < NUM_STAGE; s++) p_q[s] <= p_q[s-1];
          end
        end

        assign rs_in = p_q[NUM_STAGE-1];
      end
    end
  endgenerate

  ptcalc_mul_round_sat #(
    .P_WIDTH    (PW),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .SAT        (SAT)
  ) u_round_sat (
    .p_i    (rs_in),
    .dout_o (rs_dout),
    .sat_o  (rs_sat)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_q     <= '0;
      dout_sat_q <= 1'b0;
    end else if (advance) begin
      dout_q     <= rs_dout;
      dout_sat_q <= rs_sat;
    end
  end

  assign dout     = dout_q;
  assign dout_sat = dout_sat_q;

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr)
      sat_count_d = '0;
    else if (out_valid && out_ready && dout_sat_q && !(&sat_count_q))
      sat_count_d = sat_count_q + 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) sat_count_q <= '0;
    else           sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;

endmodule

// File: doc/ptcalc_mul_pipe.md
Name: ptcalc_mul_pipe

Overview:
- Parametrised, pipelined signed multiplier for the ptcalc datapath.
- Replaces the fixed-width single-stage combinational multiplier cells.
- Multiply depth, widths, output scaling, rounding and saturation are all configurable.
- Uses a valid/ready handshake with full backpressure, so it drops into streaming pT-calculation stages without external enable logic.
- Keeps a saturating count of clipped results for monitoring.

Parameters:
- A_WIDTH, 24, width of signed operand din0.
- B_WIDTH, 15, width of signed operand din1.
- DOUT_WIDTH, 39, width of signed result dout.
- SHIFT, 0, arithmetic right shift applied to the exact product (0 to A_WIDTH+B_WIDTH-1).
- ROUND, 1, when 1 and SHIFT>0, round half up before shifting; when 0, truncate (floor).
- SAT, 1, when 1, saturate to the DOUT range; when 0, wrap by keeping the low DOUT_WIDTH bits.
- NUM_STAGE, 3, number of register stages (>=1); this equals the latency.
- CNT_WIDTH, 16, width of sat_count.

Ports:
- ap_clk  in  1  clock; all logic is rising-edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- din0  in  A_WIDTH  signed operand A.
- din1  in  B_WIDTH  signed operand B.
- out_valid  out  1  dout is valid.
- out_ready  in  1  downstream accepts dout.
- dout  out  DOUT_WIDTH  scaled signed result.
- dout_sat  out  1  dout was clipped; qualified by out_valid.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  CNT_WIDTH  number of accepted saturated beats; sticks at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits, out_valid, dout, dout_sat and sat_count go to 0;
  - in_ready is 1 in the first cycle after release;
  - stage data registers other than the outputs are not reset.
- Pipeline control:
  - advance = !out_valid || out_ready; in_ready = advance (combinational);
  - on advance every stage shifts and stage 1 valid takes in_valid & in_ready;
  - when advance is low every stage holds;
  - bubbles are not compacted.
- Latency: exactly NUM_STAGE cycles from an accepted beat to out_valid, with out_ready held high. Throughput is one beat per cycle.
- Order: beats exit in acceptance order. None is dropped or duplicated under any out_ready pattern.
- Arithmetic:
  - The product P = din0*din1 is exact in A_WIDTH+B_WIDTH bits.
  - If ROUND=1 and SHIFT>0: R = (P + 2^(SHIFT-1)) >>> SHIFT, computed in A_WIDTH+B_WIDTH+1 bits so the addition cannot overflow. Otherwise R = P >>> SHIFT.
  - SAT=1: R above 2^(DOUT_WIDTH-1)-1 becomes that maximum; R below -2^(DOUT_WIDTH-1) becomes that minimum; dout_sat=1 whenever a clip occurs.
  - SAT=0: dout = R[DOUT_WIDTH-1:0] and dout_sat is always 0.
  - When DOUT_WIDTH >= A_WIDTH+B_WIDTH-SHIFT+1, the result is sign-extended and dout_sat is always 0.
- Stage mapping:
  - stage 1 registers the operands;
  - the multiply output is registered in stage 2;
  - extra stages are inserted after the multiply, which suits DSP M/P register retiming;
  - round/saturate is registered in the last stage;
  - NUM_STAGE=1 or 2 collapses these steps into the available stages.
- sat_count:
  - increments on out_valid & out_ready & dout_sat;
  - holds at 2^CNT_WIDTH-1 and never wraps;
  - sat_clr wins over a simultaneous increment, giving 0 on the next cycle.
- Reset mid-operation discards all in-flight beats; no partial output appears after release.
- While out_valid is high and out_ready is low, dout and dout_sat are held stable.

Decomposition:
- Shared package ptcalc_mul_pkg holds:
  - a function computing the product width (A_WIDTH+B_WIDTH);
  - functions returning the saturation max and min for a given width;
  - the round/sat mode constants.
- One sub-module, ptcalc_mul_round_sat: combinational shift/round/saturate from product width to DOUT_WIDTH, outputting the result and the clip flag. It is reused by other ptcalc scaling stages.

Test Plan:
- Defaults, single beat din0=-8388608, din1=-16384, out_ready=1 -> out_valid exactly 3 cycles later, dout=137438953472, dout_sat=0.
- SHIFT=4, ROUND=1, DOUT_WIDTH=16, din1=1, din0 = 23, 24, -24, -25 -> dout = 1, 2, -1, -2. Repeat with ROUND=0 -> 1, 1, -2, -2.
- SHIFT=0, DOUT_WIDTH=16, SAT=1: 1000*1000 -> 32767 with dout_sat=1, then -1000*1000 -> -32768 with dout_sat=1, sat_count=2. Same inputs with SAT=0 -> dout=16960, then -16960; sat_count stays 0.
- Stream 20 back-to-back beats with out_ready low for cycles 4-8 and toggling afterwards -> all 20 results exit in order with correct values; in_ready is low while the pipeline is full; dout stays stable while stalled.
- Deassert ap_rst_n with 3 beats in flight -> outputs go to 0 immediately; after release no stale out_valid appears and in_ready=1.
- Force 65536 saturated accepted beats with CNT_WIDTH=16 -> sat_count holds at 65535. sat_clr together with a saturating handshake -> sat_count=0 on the next cycle.
